// File: rtl/uart_cfg.sv
// UART with runtime baud divisor, 16x oversampled receiver, transmitter and RX/TX FIFOs.
// Define UART_PARITY_EN to add one parity bit per frame (even/odd selected by parity_odd).
module uart_cfg #(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned SB_TICK  = 16,
    parameter int unsigned DVSR_BIT = 16,
    parameter int unsigned FIFO_W   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic                parity_odd,
    input  logic                rx,
    output logic                tx,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    input  logic                rd_uart,
    output logic [DBIT-1:0]     r_data,
    input  logic                clr_err,
    output logic                tx_full,
    output logic                tx_empty,
    output logic                rx_empty,
    output logic                rx_full,
    output logic [FIFO_W:0]     tx_level,
    output logic [FIFO_W:0]     rx_level,
    output logic                tx_busy,
    output logic                frame_err,
    output logic                parity_err,
    output logic                overrun_err
);
    localparam int unsigned Depth = 1 << FIFO_W;
    localparam int unsigned TickW = 6;
    localparam int unsigned NCntW = 4;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    // Baud tick generator
    logic [DVSR_BIT-1:0] baud_cnt_q;
    logic                tick;

    assign tick = (dvsr != '0) && (baud_cnt_q >= dvsr - DVSR_BIT'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt_q <= '0;
        end else if (dvsr == '0 || tick) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_q + DVSR_BIT'(1);
        end
    end

    // RX synchroniser and receiver FSM
    logic             rx_meta_q, rx_sync_q;
    state_e           rx_state_q;
    logic [TickW-1:0] rx_s_q;
    logic [NCntW-1:0] rx_n_q;
    logic [DBIT-1:0]  rx_b_q;
    logic             rx_done_q, frame_ev_q;
`ifdef UART_PARITY_EN
    logic             rx_podd_q, par_ev_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= StIdle;
            rx_s_q     <= '0;
            rx_n_q     <= '0;
            rx_b_q     <= '0;
            rx_done_q  <= 1'b0;
            frame_ev_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_podd_q  <= 1'b0;
            par_ev_q   <= 1'b0;
`endif
        end else begin
            rx_done_q  <= 1'b0;
            frame_ev_q <= 1'b0;
`ifdef UART_PARITY_EN
            par_ev_q   <= 1'b0;
`endif
            unique case (rx_state_q)
                StIdle: begin
                    // A halted baud generator also freezes the receiver in idle
                    if (!rx_sync_q && dvsr != '0) begin
                        rx_state_q <= StStart;
                        rx_s_q     <= '0;
`ifdef UART_PARITY_EN
                        rx_podd_q  <= parity_odd;
`endif
                    end
                end
                StStart: begin
                    if (tick) begin
                        if (rx_s_q == TickW'(7)) begin
                            rx_state_q <= rx_sync_q ? StIdle : StData;
                            rx_s_q     <= '0;
                            rx_n_q     <= '0;
                        end else begin
                            rx_s_q <= rx_s_q + TickW'(1);
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        if (rx_s_q == TickW'(15)) begin
                            rx_s_q <= '0;
                            rx_b_q <= {rx_sync_q, rx_b_q[DBIT-1:1]};
                            if (rx_n_q == NCntW'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
                                rx_state_q <= StParity;
`else
                                rx_state_q <= StStop;
`endif
                            end else begin
                                rx_n_q <= rx_n_q + NCntW'(1);
                            end
                        end else begin
                            rx_s_q <= rx_s_q + TickW'(1);
                        end
                    end
                end
`ifdef UART_PARITY_EN
                StParity: begin
                    if (tick) begin
                        if (rx_s_q == TickW'(15)) begin
                            rx_s_q     <= '0;
                            par_ev_q   <= (^rx_b_q) ^ rx_sync_q ^ rx_podd_q;
                            rx_state_q <= StStop;
                        end else begin
                            rx_s_q <= rx_s_q + TickW'(1);
                        end
                    end
                end
`endif
                StStop: begin
                    if (tick) begin
                        if (rx_s_q == TickW'(SB_TICK - 1)) begin
                            rx_state_q <= StIdle;
                            rx_done_q  <= 1'b1;
                            frame_ev_q <= !rx_sync_q;
                        end else begin
                            rx_s_q <= rx_s_q + TickW'(1);
                        end
                    end
                end
                default: rx_state_q <= StIdle;
            endcase
        end
    end

    // RX FIFO: a completed word arriving while full is dropped even if a read is pending
    logic [DBIT-1:0] rx_mem_q [Depth];
    logic [FIFO_W:0] rx_wptr_q, rx_rptr_q;
    logic            rx_we, rx_re;

    assign rx_level = rx_wptr_q - rx_rptr_q;
    assign rx_empty = (rx_level == '0);
    assign rx_full  = (rx_level == (FIFO_W + 1)'(Depth));
    assign rx_we    = rx_done_q && !rx_full;
    assign rx_re    = rd_uart && !rx_empty;
    assign r_data   = rx_mem_q[rx_rptr_q[FIFO_W-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) rx_mem_q[i] <= '0;
        end else begin
            if (rx_we) begin
                rx_mem_q[rx_wptr_q[FIFO_W-1:0]] <= rx_b_q;
                rx_wptr_q <= rx_wptr_q + (FIFO_W + 1)'(1);
            end
            if (rx_re) rx_rptr_q <= rx_rptr_q + (FIFO_W + 1)'(1);
        end
    end

    // TX FIFO
    logic [DBIT-1:0] tx_mem_q [Depth];
    logic [FIFO_W:0] tx_wptr_q, tx_rptr_q;
    logic [DBIT-1:0] tx_head;
    logic            tx_we, tx_load;

    assign tx_level = tx_wptr_q - tx_rptr_q;
    assign tx_empty = (tx_level == '0);
    assign tx_full  = (tx_level == (FIFO_W + 1)'(Depth));
    assign tx_we    = wr_uart && (!tx_full || tx_load);
    assign tx_head  = tx_mem_q[tx_rptr_q[FIFO_W-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) tx_mem_q[i] <= '0;
        end else begin
            if (tx_we) begin
                tx_mem_q[tx_wptr_q[FIFO_W-1:0]] <= w_data;
                tx_wptr_q <= tx_wptr_q + (FIFO_W + 1)'(1);
            end
            if (tx_load) tx_rptr_q <= tx_rptr_q + (FIFO_W + 1)'(1);
        end
    end

    // Transmitter FSM; the last stop tick can reload directly so back-to-back frames have no gap
    state_e           tx_state_q;
    logic [TickW-1:0] tx_s_q;
    logic [NCntW-1:0] tx_n_q;
    logic [DBIT-1:0]  tx_b_q;
    logic             tx_q, tx_busy_q;
`ifdef UART_PARITY_EN
    logic             tx_par_q;
`endif

    assign tx_load = tick && !tx_empty && (tx_state_q == StIdle ||
                     (tx_state_q == StStop && tx_s_q == TickW'(SB_TICK - 1)));
    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= StIdle;
            tx_s_q     <= '0;
            tx_n_q     <= '0;
            tx_b_q     <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else if (tx_load) begin
            tx_state_q <= StStart;
            tx_s_q     <= '0;
            tx_b_q     <= tx_head;
            tx_q       <= 1'b0;
            tx_busy_q  <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= (^tx_head) ^ parity_odd;
`endif
        end else if (tick) begin
            unique case (tx_state_q)
                StIdle: tx_q <= 1'b1;
                StStart: begin
                    if (tx_s_q == TickW'(15)) begin
                        tx_state_q <= StData;
                        tx_s_q     <= '0;
                        tx_n_q     <= '0;
                        tx_q       <= tx_b_q[0];
                    end else begin
                        tx_s_q <= tx_s_q + TickW'(1);
                    end
                end
                StData: begin
                    if (tx_s_q == TickW'(15)) begin
                        tx_s_q <= '0;
                        tx_b_q <= {1'b0, tx_b_q[DBIT-1:1]};
                        if (tx_n_q == NCntW'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
                            tx_state_q <= StParity;
                            tx_q       <= tx_par_q;
`else
                            tx_state_q <= StStop;
                            tx_q       <= 1'b1;
`endif
                        end else begin
                            tx_n_q <= tx_n_q + NCntW'(1);
                            tx_q   <= tx_b_q[1];
                        end
                    end else begin
                        tx_s_q <= tx_s_q + TickW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                StParity: begin
                    if (tx_s_q == TickW'(15)) begin
                        tx_s_q     <= '0;
                        tx_state_q <= StStop;
                        tx_q       <= 1'b1;
                    end else begin
                        tx_s_q <= tx_s_q + TickW'(1);
                    end
                end
`endif
                StStop: begin
                    if (tx_s_q == TickW'(SB_TICK - 1)) begin
                        tx_state_q <= StIdle;
                        tx_busy_q  <= 1'b0;
                        tx_q       <= 1'b1;
                    end else begin
                        tx_s_q <= tx_s_q + TickW'(1);
                    end
                end
                default: tx_state_q <= StIdle;
            endcase
        end
    end

    // Sticky error flags: a new event wins over a simultaneous clear
    logic frame_err_q, overrun_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            frame_err_q   <= frame_ev_q | (frame_err_q & ~clr_err);
            overrun_err_q <= (rx_done_q & rx_full) | (overrun_err_q & ~clr_err);
        end
    end

    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

`ifdef UART_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) parity_err_q <= 1'b0;
        else       parity_err_q <= par_ev_q | (parity_err_q & ~clr_err);
    end

    assign parity_err = parity_err_q;
`else
    logic unused_parity_odd;

    assign unused_parity_odd = parity_odd;
    assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cfg.sv
// Scoreboard bench for uart_cfg: expected RX/TX words are queued at stimulus time and
// checked by independent monitors on RX FIFO reads and on the decoded serial tx line.
module tb_uart_cfg;
    localparam int DBIT     = 8;
    localparam int SB_TICK  = 16;
    localparam int DVSR_BIT = 16;
    localparam int FIFO_W   = 2;
    localparam int BitClk   = 64;  // clocks per bit at dvsr=4

    logic                clk = 1'b0;
    logic                reset;
    logic [DVSR_BIT-1:0] dvsr;
    logic                parity_odd;
    logic                rx;
    logic                tx;
    logic                wr_uart;
    logic [DBIT-1:0]     w_data;
    logic                rd_uart;
    logic [DBIT-1:0]     r_data;
    logic                clr_err;
    logic                tx_full, tx_empty, rx_empty, rx_full;
    logic [FIFO_W:0]     tx_level, rx_level;
    logic                tx_busy, frame_err, parity_err, overrun_err;

    always #5 clk = ~clk;

    uart_cfg #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK),
        .DVSR_BIT(DVSR_BIT),
        .FIFO_W  (FIFO_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dvsr       (dvsr),
        .parity_odd (parity_odd),
        .rx         (rx),
        .tx         (tx),
        .wr_uart    (wr_uart),
        .w_data     (w_data),
        .rd_uart    (rd_uart),
        .r_data     (r_data),
        .clr_err    (clr_err),
        .tx_full    (tx_full),
        .tx_empty   (tx_empty),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .tx_level   (tx_level),
        .rx_level   (rx_level),
        .tx_busy    (tx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun_err(overrun_err)
    );

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [DBIT-1:0] rx_exp[$];
    logic [DBIT-1:0] tx_exp[$];
    bit              tx_rst_seen = 1'b0;
`ifdef UART_PARITY_EN
    logic            par_flip = 1'b0;
`endif

    always @(posedge reset) tx_rst_seen = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // RX monitor: every accepted read is matched against the next expected word
    initial begin : rx_monitor
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && rd_uart && !rx_empty) begin
                if (rx_exp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected_word: got 0x%0h, expected none", r_data);
                end else begin
                    check("rx_word", 32'(r_data), 32'(rx_exp.pop_front()));
                end
            end
        end
    end

    // TX monitor: decodes each frame at mid-bit; frames cut by reset are discarded
    initial begin : tx_monitor
        logic [DBIT-1:0] word;
        logic [DBIT-1:0] exp;
        logic            start_bit, stop_bit, busy_all;
`ifdef UART_PARITY_EN
        logic            par_bit;
`endif
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                tx_rst_seen = 1'b0;
                repeat (BitClk / 2 - 1) @(negedge clk);
                start_bit = tx;
                busy_all  = tx_busy;
                for (int i = 0; i < DBIT; i++) begin
                    repeat (BitClk) @(negedge clk);
                    word[i]  = tx;
                    busy_all = busy_all & tx_busy;
                end
`ifdef UART_PARITY_EN
                repeat (BitClk) @(negedge clk);
                par_bit = tx;
`endif
                repeat (BitClk) @(negedge clk);
                stop_bit = tx;
                busy_all = busy_all & tx_busy;
                if (!tx_rst_seen) begin
                    if (tx_exp.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_unexpected_frame: got 0x%0h, expected none", word);
                    end else begin
                        exp = tx_exp.pop_front();
                        check("tx_start_bit", 32'(start_bit), 32'(0));
                        check("tx_word", 32'(word), 32'(exp));
`ifdef UART_PARITY_EN
                        check("tx_parity_bit", 32'(par_bit), 32'((^exp) ^ parity_odd));
`endif
                        check("tx_stop_bit", 32'(stop_bit), 32'(1));
                        check("tx_busy_in_frame", 32'(busy_all), 32'(1));
                    end
                end
            end
        end
    end

    task automatic write_tx(input logic [DBIT-1:0] d, input bit expect_sent);
        if (expect_sent) tx_exp.push_back(d);
        @(posedge clk);
        #1;
        wr_uart = 1'b1;
        w_data  = d;
        @(posedge clk);
        #1;
        wr_uart = 1'b0;
    endtask

    task automatic read_rx();
        @(posedge clk);
        #1;
        rd_uart = 1'b1;
        @(posedge clk);
        #1;
        rd_uart = 1'b0;
    endtask

    task automatic clear_errors();
        @(posedge clk);
        #1;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DBIT-1:0] d, input logic stop_v, input int stop_clks,
                              input bit deliver);
        if (deliver) rx_exp.push_back(d);
        rx = 1'b0;
        repeat (BitClk) @(posedge clk);
        for (int i = 0; i < DBIT; i++) begin
            rx = d[i];
            repeat (BitClk) @(posedge clk);
        end
`ifdef UART_PARITY_EN
        rx = (^d) ^ parity_odd ^ par_flip;
        repeat (BitClk) @(posedge clk);
`endif
        rx = stop_v;
        repeat (stop_clks) @(posedge clk);
        rx = 1'b1;
        repeat (BitClk) @(posedge clk);
        #1;
    endtask

    task automatic wait_rx_word(input int max_clks);
        int n = 0;
        while (rx_empty && n < max_clks) begin
            @(negedge clk);
            n++;
        end
        check("rx_word_arrival", 32'(rx_empty), 32'(0));
    endtask

    task automatic wait_tx_done(input int max_clks);
        int n = 0;
        while ((tx_busy || !tx_empty) && n < max_clks) begin
            @(negedge clk);
            n++;
        end
        check("tx_drain", 32'({tx_busy, tx_empty}), 32'(2'b01));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int low;
        reset      = 1'b0;
        dvsr       = 16'd4;
        parity_odd = 1'b0;
        rx         = 1'b1;
        wr_uart    = 1'b0;
        w_data     = '0;
        rd_uart    = 1'b0;
        clr_err    = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_tx", 32'(tx), 32'(1));
        check("rst_tx_busy", 32'(tx_busy), 32'(0));
        check("rst_errors", 32'({frame_err, parity_err, overrun_err}), 32'(0));
        check("rst_empty", 32'({tx_empty, rx_empty}), 32'(2'b11));
        check("rst_full", 32'({tx_full, rx_full}), 32'(0));
        check("rst_levels", 32'({tx_level, rx_level}), 32'(0));
        check("rst_r_data", 32'(r_data), 32'(0));
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single TX frame 0xA5: start bit lasts exactly 16 ticks of 4 clocks
        write_tx(8'hA5, 1'b1);
        @(negedge clk);
        n = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tx_start_seen", 32'(tx), 32'(0));
        check("tx_busy_at_start", 32'(tx_busy), 32'(1));
        check("tx_empty_after_pop", 32'(tx_empty), 32'(1));
        low = 0;
        while (tx === 1'b0 && low < 200) begin
            @(negedge clk);
            low++;
        end
        check("tx_start_len", 32'(low), 32'(64));
        wait_tx_done(1000);

        // Halted baud generator: FIFO fills to depth, extra write ignored, line stays idle
        dvsr = 16'd0;
        write_tx(8'h01, 1'b1);
        write_tx(8'h80, 1'b1);
        write_tx(8'h3E, 1'b1);
        check("tx_level_3", 32'(tx_level), 32'(3));
        write_tx(8'hC3, 1'b1);
        check("tx_full_4", 32'({tx_full, tx_level}), 32'({1'b1, 3'd4}));
        write_tx(8'hFF, 1'b0);
        check("tx_level_after_ovf_write", 32'(tx_level), 32'(4));
        check("tx_halted_idle", 32'({tx, tx_busy}), 32'(2'b10));
        dvsr = 16'd4;
        wait_tx_done(4000);

        // Single RX frame 0x3C
        send_frame(8'h3C, 1'b1, BitClk, 1'b1);
        wait_rx_word(200);
        check("rx_r_data_3c", 32'(r_data), 32'h3C);
        check("rx_level_1", 32'(rx_level), 32'(1));
        read_rx();
        check("rx_empty_after_read", 32'(rx_empty), 32'(1));

        // 100-clock glitch at dvsr=16 is a false start
        dvsr = 16'd16;
        repeat (20) @(posedge clk);
        rx = 1'b0;
        repeat (100) @(posedge clk);
        rx = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        check("glitch_no_word", 32'({rx_empty, rx_level}), 32'({1'b1, 3'd0}));
        check("glitch_no_error", 32'({frame_err, parity_err, overrun_err}), 32'(0));
        dvsr = 16'd4;
        repeat (20) @(posedge clk);

        // Five frames without reads: fifth is dropped and flags overrun
        send_frame(8'h11, 1'b1, BitClk, 1'b1);
        send_frame(8'h22, 1'b1, BitClk, 1'b1);
        send_frame(8'h33, 1'b1, BitClk, 1'b1);
        send_frame(8'h44, 1'b1, BitClk, 1'b1);
        check("rx_no_overrun_at_4", 32'(overrun_err), 32'(0));
        send_frame(8'h55, 1'b1, BitClk, 1'b0);
        check("rx_full_level", 32'({rx_full, rx_level}), 32'({1'b1, 3'd4}));
        check("overrun_set", 32'(overrun_err), 32'(1));
        check("rx_head_kept", 32'(r_data), 32'h11);
        clear_errors();
        check("overrun_cleared", 32'(overrun_err), 32'(0));
        repeat (4) read_rx();
        check("rx_drained", 32'(rx_empty), 32'(1));

        // Stop bit held low: framing error, word still delivered exactly once
        send_frame(8'h5A, 1'b0, 48, 1'b1);
        wait_rx_word(200);
        check("frame_err_set", 32'(frame_err), 32'(1));
        check("frame_err_one_word", 32'(rx_level), 32'(1));
        read_rx();
        clear_errors();
        check("frame_err_cleared", 32'(frame_err), 32'(0));

`ifdef UART_PARITY_EN
        // Corrupted even parity bit
        parity_odd = 1'b0;
        par_flip   = 1'b1;
        send_frame(8'h5A, 1'b1, BitClk, 1'b1);
        par_flip   = 1'b0;
        wait_rx_word(200);
        check("parity_err_set", 32'({parity_err, frame_err}), 32'(2'b10));
        read_rx();
        clear_errors();
        check("parity_err_cleared", 32'(parity_err), 32'(0));
`endif

        // Reset during TX data bits of 0xF0 with 0x0F still queued
        write_tx(8'hF0, 1'b0);
        write_tx(8'h0F, 1'b0);
        @(negedge clk);
        n = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (BitClk + 100) @(negedge clk);
        check("tx_in_data_low", 32'(tx), 32'(0));
        check("tx_level_queued", 32'(tx_level), 32'(1));
        #2 reset = 1'b1;
        #1;
        check("async_rst_tx", 32'(tx), 32'(1));
        check("async_rst_level", 32'({tx_level, tx_empty}), 32'({3'd0, 1'b1}));
        check("async_rst_busy", 32'(tx_busy), 32'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (700) @(posedge clk);
        #1;
        write_tx(8'h96, 1'b1);
        wait_tx_done(1000);
        repeat (10) @(negedge clk);

        check("tx_queue_drained", 32'(tx_exp.size()), 32'(0));
        check("rx_queue_drained", 32'(rx_exp.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
